// File: rtl/alu_serial.sv
// Bit-serial ALU: WIDTH-bit operands processed LSB-first through one 1-bit slice, one bit per clock.
// Define ALU_SERIAL_FLAGS_EN to build the zero/overflow flag logic; otherwise zero and ovf are tied low.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             last;
    logic             finish;
    logic             a_bit, b_bit, b_eff, c_next;
    logic             left_bit, right_bit;
    logic             slice_bit;

    // One-bit slice: operand bits picked by the bit counter from the latched copies.
    always_comb begin
        a_bit = a_q[cnt_q];
        b_bit = b_q[cnt_q];

        unique case (op_q)
            2'b00:   b_eff = b_bit;
            2'b01:   b_eff = ~b_bit;
            2'b10:   b_eff = 1'b0;
            default: b_eff = 1'b1;
        endcase
        c_next = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

        // Shift neighbours; the ends insert 0 for logical shifts or wrap for rotates.
        if (cnt_q == '0)
            left_bit = op_q[1] ? a_q[WIDTH-1] : 1'b0;
        else
            left_bit = a_q[cnt_q - 1'b1];
        if (cnt_q == LAST)
            right_bit = op_q[1] ? a_q[0] : 1'b0;
        else
            right_bit = a_q[cnt_q + 1'b1];

        unique case (mode_q)
            2'b00: begin
                unique case (op_q)
                    2'b00:   slice_bit = a_bit & b_bit;
                    2'b01:   slice_bit = a_bit | b_bit;
                    2'b10:   slice_bit = a_bit ^ b_bit;
                    default: slice_bit = ~a_bit;
                endcase
            end
            2'b01:   slice_bit = a_bit ^ b_eff ^ carry_q;
            2'b10:   slice_bit = op_q[0] ? right_bit : left_bit;
            default: slice_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sh_d     = sh_q;
        result_d = result_q;
        cout_d   = cout_q;

        accept = start && (state_q != RUN);
        last   = (cnt_q == LAST);
        finish = (state_q == RUN) && last;

        unique case (state_q)
            RUN: begin
                sh_d[cnt_q] = slice_bit;
                carry_d     = c_next;
                if (last) begin
                    state_d  = DONE;
                    result_d = sh_d;
                    unique case (mode_q)
                        2'b01:   cout_d = c_next;
                        2'b10:   cout_d = op_q[0] ? a_q[0] : a_q[WIDTH-1];
                        default: cout_d = 1'b0;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!accept)
                    state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = ain;
            b_d     = bin;
            mode_d  = mode;
            op_d    = opcode;
            cnt_d   = '0;
            sh_d    = '0;
            // Subtract and increment start with carry-in 1; every other op starts at 0.
            carry_d = (mode == 2'b01) && (opcode == 2'b01 || opcode == 2'b10);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sh_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;

    // On the MSB cycle carry_q is the carry into the MSB and c_next the carry out of it.
    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (finish) begin
            zero_d = (sh_d == '0);
            ovf_d  = (mode_q == 2'b01) && (carry_q ^ c_next);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    logic unused_finish;
    assign unused_finish = finish;
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed-vector bench for alu_serial at WIDTH=8: table of single ops plus back-to-back, mid-run and reset sequences.
module tb_alu_serial;

    localparam int W = 8;
`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = '0;
    logic [1:0]   opcode = '0;
    logic [W-1:0] ain = '0;
    logic [W-1:0] bin = '0;
    logic         busy, done, cout, zero, ovf;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .mode   (mode),
        .opcode (opcode),
        .ain    (ain),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         zf;
        logic         of;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Waits for done after an accept edge; returns edges counted (0 means the bound expired).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        mode = m; opcode = op; ain = a; bin = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " cout"},   32'(cout),   32'(v.c));
        check({tag, " zero"},   32'(zero),   32'(FLAGS & v.zf));
        check({tag, " ovf"},    32'(ovf),    32'(FLAGS & v.of));
        check({tag, " busy_at_done"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int   lat;
        vec_t v;
        bit   saw_done;

        //                mode   op     A      B      result c  z  v
        vecs[0]  = '{2'b01, 2'b00, 8'hFF, 8'h01, 8'h00, 1, 1, 0};
        vecs[1]  = '{2'b01, 2'b01, 8'h05, 8'h07, 8'hFE, 0, 0, 0};
        vecs[2]  = '{2'b01, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 0, 1};
        vecs[3]  = '{2'b00, 2'b10, 8'hA5, 8'h0F, 8'hAA, 0, 0, 0};
        vecs[4]  = '{2'b00, 2'b11, 8'hA5, 8'h0F, 8'h5A, 0, 0, 0};
        vecs[5]  = '{2'b10, 2'b11, 8'h81, 8'h00, 8'hC0, 1, 0, 0};
        vecs[6]  = '{2'b10, 2'b00, 8'h81, 8'h00, 8'h02, 1, 0, 0};
        vecs[7]  = '{2'b00, 2'b00, 8'hA5, 8'h0F, 8'h05, 0, 0, 0};
        vecs[8]  = '{2'b00, 2'b01, 8'hA5, 8'h0F, 8'hAF, 0, 0, 0};
        vecs[9]  = '{2'b00, 2'b00, 8'hF0, 8'h0F, 8'h00, 0, 1, 0};
        vecs[10] = '{2'b01, 2'b10, 8'hFF, 8'h00, 8'h00, 1, 1, 0};
        vecs[11] = '{2'b01, 2'b11, 8'h00, 8'h00, 8'hFF, 0, 0, 0};
        vecs[12] = '{2'b01, 2'b11, 8'h80, 8'h00, 8'h7F, 1, 0, 1};
        vecs[13] = '{2'b01, 2'b01, 8'h07, 8'h05, 8'h02, 1, 0, 0};
        vecs[14] = '{2'b10, 2'b01, 8'h81, 8'h00, 8'h40, 1, 0, 0};
        vecs[15] = '{2'b10, 2'b10, 8'h81, 8'h00, 8'h03, 1, 0, 0};
        vecs[16] = '{2'b11, 2'b01, 8'hFF, 8'hFF, 8'h00, 0, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy",   32'(busy),   32'(0));
        check("reset done",   32'(done),   32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset cout",   32'(cout),   32'(0));
        check("reset zero",   32'(zero),   32'(0));
        check("reset ovf",    32'(ovf),    32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            launch(v.mode, v.op, v.a, v.b);
            check($sformatf("vec%0d busy_after_accept", i), 32'(busy), 32'(1));
            wait_done(lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
            check_outputs($sformatf("vec%0d", i), v);
            @(posedge clk); #1;
            check($sformatf("vec%0d done_width", i), 32'(done), 32'(0));
            $display("vec%0d mode=%b op=%b A=%h B=%h -> result=%h cout=%b zero=%b ovf=%b lat=%0d",
                     i, v.mode, v.op, v.a, v.b, result, cout, zero, ovf, lat);
        end

        // Back-to-back: start held through DONE with a new operand pair.
        launch(2'b01, 2'b00, 8'h7F, 8'h01);
        start = 1'b1;
        wait_done(lat);
        check("b2b first latency", 32'(lat), 32'(W));
        check("b2b first result", 32'(result), 32'h80);
        ain = 8'h12; bin = 8'h34;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b second accepted", 32'(busy), 32'(1));
        wait_done(lat);
        check("b2b second latency", 32'(lat), 32'(W));
        check("b2b second result", 32'(result), 32'h46);
        $display("b2b 7F+01 then 12+34 -> result=%h lat=%0d", result, lat);
        @(posedge clk); #1;

        // Mid-run: start pulses and operand changes while busy are ignored.
        launch(2'b01, 2'b00, 8'h33, 8'h11);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; ain = 8'hFF; bin = 8'hFF; mode = 2'b00; opcode = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        lat = 0;
        for (int k = 5; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("midrun latency", 32'(lat), 32'(W));
        check("midrun result", 32'(result), 32'h44);
        check("midrun cout", 32'(cout), 32'(0));
        $display("midrun 33+11 with toggles -> result=%h lat=%0d", result, lat);
        @(posedge clk); #1;

        // Reset at E0+3 aborts the add without a done pulse.
        launch(2'b01, 2'b00, 8'h12, 8'h34);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort busy",   32'(busy),   32'(0));
        check("abort done",   32'(done),   32'(0));
        check("abort result", 32'(result), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", 32'(saw_done), 32'(0));
        $display("abort add 12+34 at E0+3 -> busy=%b result=%h done_seen=%b", busy, result, saw_done);

        launch(2'b01, 2'b00, 8'h12, 8'h34);
        wait_done(lat);
        check("post_abort latency", 32'(lat), 32'(W));
        check("post_abort result", 32'(result), 32'h46);
        $display("post_abort 12+34 -> result=%h lat=%0d", result, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
